// File: rtl/imem_uart_loader.sv
// imem_uart_loader: parses framed program images from the UART receiver and
// writes them word-by-word into instruction RAM, holding fetch in reset
// (memcon_prog_ena) until a frame with a matching checksum has been loaded.
//
// Handshake: uart_rx_valid is a one-cycle strobe qualifying uart_dout; there
// is no ready, every strobed byte is consumed in the cycle it is presented,
// including strobes on consecutive cycles. imem_we is a one-cycle write strobe
// with imem_waddr/imem_wdata valid in the same cycle.
module imem_uart_loader #(
    parameter int          IMEM_WORDS  = 1024,
    parameter int          ADDR_W      = 10,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int          TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk,
    input  logic              Rst,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_dout,
    output logic              memcon_prog_ena,
    output logic [3:0]        imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              load_done,
    output logic              load_err,
    output logic [ADDR_W:0]   words_loaded,
    output logic [2:0]        dbg_state
);

    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4
    } state_t;

    state_t            state;
    logic [7:0]        len_lo;
    logic [ADDR_W:0]   len_q;      // N, already bounded by IMEM_WORDS
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        lane;
    logic [23:0]       shreg;      // bytes 0..2 of the word being assembled
    logic [7:0]        sum;
    logic [TO_W-1:0]   to_cnt;

    logic [15:0]       len_n;
    logic [ADDR_W:0]   next_idx;

    assign len_n     = {uart_dout, len_lo};
    assign next_idx  = word_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign dbg_state = state;

    // Frame parser, write generation, status flags and inter-byte timeout.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            state           <= S_IDLE;
            len_lo          <= '0;
            len_q           <= '0;
            word_idx        <= '0;
            lane            <= '0;
            shreg           <= '0;
            sum             <= '0;
            to_cnt          <= '0;
            memcon_prog_ena <= 1'b0;
            imem_we         <= 4'h0;
            imem_waddr      <= '0;
            imem_wdata      <= '0;
            load_done       <= 1'b0;
            load_err        <= 1'b0;
            words_loaded    <= '0;
        end else begin
            imem_we   <= 4'h0;
            load_done <= 1'b0;

            if (state == S_IDLE) begin
                to_cnt <= '0;
                if (uart_rx_valid && uart_dout == SYNC_BYTE) begin
                    state           <= S_LEN_LO;
                    memcon_prog_ena <= 1'b1;
                    load_err        <= 1'b0;
                    word_idx        <= '0;
                    lane            <= '0;
                    sum             <= '0;
                end
            end else if (uart_rx_valid) begin
                to_cnt <= '0;
                case (state)
                    S_LEN_LO: begin
                        len_lo <= uart_dout;
                        state  <= S_LEN_HI;
                    end
                    S_LEN_HI: begin
                        if ({16'd0, len_n} > 32'(IMEM_WORDS)) begin
                            load_err <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            len_q <= len_n[ADDR_W:0];
                            state <= (len_n == 16'd0) ? S_CSUM : S_DATA;
                        end
                    end
                    S_DATA: begin
                        sum  <= sum + uart_dout;
                        lane <= lane + 2'd1;
                        if (lane == 2'd3) begin
                            imem_we    <= 4'hF;
                            imem_waddr <= word_idx[ADDR_W-1:0];
                            imem_wdata <= {uart_dout, shreg};
                            word_idx   <= next_idx;
                            if (next_idx == len_q)
                                state <= S_CSUM;
                        end else begin
                            shreg <= {uart_dout, shreg[23:8]};
                        end
                    end
                    S_CSUM: begin
                        if (uart_dout == sum) begin
                            memcon_prog_ena <= 1'b0;
                            load_done       <= 1'b1;
                            words_loaded    <= len_q;
                        end else begin
                            load_err <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                // TIMEOUT_CYC clocks without a byte: abandon the frame, stay held.
                to_cnt   <= '0;
                load_err <= 1'b1;
                state    <= S_IDLE;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_imem_uart_loader.sv
// Directed bench for imem_uart_loader: frames are driven byte by byte, the
// expected RAM writes and load_done counts are queued as each frame is issued
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_imem_uart_loader;

    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 40;

    logic              clk;
    logic              Rst;
    logic              uart_rx_valid;
    logic [7:0]        uart_dout;
    logic              memcon_prog_ena;
    logic [3:0]        imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   words_loaded;
    logic [2:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W+31:0] exp_q[$];       // {addr, data} of expected writes
    logic [ADDR_W:0]    exp_done_q[$];  // words_loaded at each load_done
    logic [7:0]         frame[$];

    imem_uart_loader #(
        .IMEM_WORDS (1024),
        .ADDR_W     (ADDR_W),
        .SYNC_BYTE  (8'hA5),
        .TIMEOUT_CYC(TIMEOUT)
    ) dut (
        .clk            (clk),
        .Rst            (Rst),
        .uart_rx_valid  (uart_rx_valid),
        .uart_dout      (uart_dout),
        .memcon_prog_ena(memcon_prog_ena),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .load_done      (load_done),
        .load_err       (load_err),
        .words_loaded   (words_loaded),
        .dbg_state      (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // driver: one byte per strobe, gap idle cycles between bytes (0 = back-to-back)
    task automatic send_frame(input int gap);
        for (int i = 0; i < frame.size(); i++) begin
            uart_rx_valid = 1'b1;
            uart_dout     = frame[i];
            @(negedge clk);
            uart_rx_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, " prog_ena"}, 64'(memcon_prog_ena), 64'd0);
        check({tag, " we"},       64'(imem_we),         64'd0);
        check({tag, " waddr"},    64'(imem_waddr),      64'd0);
        check({tag, " wdata"},    64'(imem_wdata),      64'd0);
        check({tag, " done"},     64'(load_done),       64'd0);
        check({tag, " err"},      64'(load_err),        64'd0);
        check({tag, " words"},    64'(words_loaded),    64'd0);
        check({tag, " state"},    64'(dbg_state),       64'd0);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!Rst) begin
            if (imem_we != 4'h0) begin
                check("we_pattern", 64'(imem_we), 64'hF);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", imem_waddr, imem_wdata);
                end else begin
                    check("write", 64'({imem_waddr, imem_wdata}), 64'(exp_q.pop_front()));
                end
            end
            if (load_done) begin
                if (exp_done_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got words %0d expected no pulse", words_loaded);
                end else begin
                    check("done_words", 64'(words_loaded), 64'(exp_done_q.pop_front()));
                end
            end
        end
    end

    initial begin
        Rst = 1'b1;
        uart_rx_valid = 1'b0;
        uart_dout = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        Rst = 1'b0;
        @(negedge clk);

        // two-word image; checksum = 13+93+10 = B6
        frame = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                  8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
        exp_q.push_back({10'd0, 32'h00000013});
        exp_q.push_back({10'd1, 32'h00100093});
        exp_done_q.push_back(11'd2);
        send_frame(1);
        settle();
        check("good prog_ena", 64'(memcon_prog_ena), 64'd0);
        check("good err",      64'(load_err),        64'd0);
        check("good words",    64'(words_loaded),    64'd2);

        // bad checksum: writes still happen, core stays held, no done
        frame[11] = 8'h00;
        exp_q.push_back({10'd0, 32'h00000013});
        exp_q.push_back({10'd1, 32'h00100093});
        send_frame(0);
        settle();
        check("badcs err",      64'(load_err),        64'd1);
        check("badcs prog_ena", 64'(memcon_prog_ena), 64'd1);

        // correct frame clears the error and releases fetch
        frame[11] = 8'hB6;
        exp_q.push_back({10'd0, 32'h00000013});
        exp_q.push_back({10'd1, 32'h00100093});
        exp_done_q.push_back(11'd2);
        send_frame(2);
        settle();
        check("recover err",      64'(load_err),        64'd0);
        check("recover prog_ena", 64'(memcon_prog_ena), 64'd0);

        // N = 1025 exceeds depth; trailing bytes are ignored in IDLE
        frame = '{8'hA5, 8'h01, 8'h04};
        send_frame(0);
        settle();
        check("toolong err",      64'(load_err),        64'd1);
        check("toolong state",    64'(dbg_state),       64'd0);
        check("toolong prog_ena", 64'(memcon_prog_ena), 64'd1);
        frame = '{8'h00, 8'h00};
        send_frame(0);
        settle();
        check("ignored state", 64'(dbg_state), 64'd0);

        // exactly N = 1024 is accepted as a length (no error after LEN_HI)
        frame = '{8'hA5, 8'h00, 8'h04};
        send_frame(0);
        check("maxlen state", 64'(dbg_state), 64'd3);
        check("maxlen err",   64'(load_err),  64'd0);
        Rst = 1'b1;
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);

        // empty image
        frame = '{8'hA5, 8'h00, 8'h00, 8'h00};
        exp_done_q.push_back(11'd0);
        send_frame(0);
        settle();
        check("empty words",    64'(words_loaded),    64'd0);
        check("empty prog_ena", 64'(memcon_prog_ena), 64'd0);

        // sync value inside data is ordinary data; checksum A5+11+22+33 = 0B
        frame = '{8'hA5, 8'h01, 8'h00, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h0B};
        exp_q.push_back({10'd0, 32'h332211A5});
        exp_done_q.push_back(11'd1);
        send_frame(1);
        settle();
        check("syncdata err", 64'(load_err), 64'd0);

        // timeout mid-word: no write, error, held
        frame = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22};
        send_frame(0);
        repeat (TIMEOUT - 3) @(negedge clk);
        check("pre_timeout err", 64'(load_err), 64'd0);
        repeat (5) @(negedge clk);
        check("timeout err",      64'(load_err),        64'd1);
        check("timeout state",    64'(dbg_state),       64'd0);
        check("timeout prog_ena", 64'(memcon_prog_ena), 64'd1);

        // asynchronous reset mid-DATA, checked before the next rising edge
        frame = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        exp_q.push_back({10'd0, 32'h44332211});
        send_frame(0);
        #2;
        Rst = 1'b1;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        Rst = 1'b0;
        @(negedge clk);

        // twelve back-to-back strobes; checksum 1+2+..+8 = 24
        frame = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                  8'h05, 8'h06, 8'h07, 8'h08, 8'h24};
        exp_q.push_back({10'd0, 32'h04030201});
        exp_q.push_back({10'd1, 32'h08070605});
        exp_done_q.push_back(11'd2);
        send_frame(0);
        settle();
        check("b2b prog_ena", 64'(memcon_prog_ena), 64'd0);
        check("b2b words",    64'(words_loaded),    64'd2);

        check("writes drained", 64'(exp_q.size()),      64'd0);
        check("dones drained",  64'(exp_done_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // global time limit
    initial begin
        #200000;
        $display("FAIL time_limit: got no finish expected finish before 200000");
        $fatal(1);
    end

endmodule
